// File: rtl/sdram_write.sv
// sdram_write: write-path engine of the wb_sdram slave.
// Drains 32-bit FIFO words as two 16-bit columns, upper half first.
module sdram_write #(
  parameter int unsigned T_RCD = 2,
  parameter int unsigned T_WR  = 2,
  parameter int unsigned T_RP  = 2,
  parameter int unsigned T_RFC = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [2:0]  command,
  output logic [11:0] addr,
  output logic [1:0]  bank,
  output logic [15:0] data_out,
  output logic [1:0]  data_mask,
  input  logic        en,
  input  logic [21:0] write_address,
  output logic        ready,
  input  logic        auto_rfrsh,
  input  logic [31:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd
);

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_AR  = 3'b001;

  localparam logic [3:0] D_RCD = 4'(T_RCD - 1);
  localparam logic [3:0] D_WR  = 4'(T_WR);
  localparam logic [3:0] D_RP  = 4'(T_RP - 1);
  localparam logic [3:0] D_RFC = 4'(T_RFC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_WRITE_TOP,
    S_WRITE_BOTTOM,
    S_PRECHARGE,
    S_REFRESH
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  delay_q, delay_d;
  logic        lauto_q, lauto_d;
  logic [21:0] laddr_q, laddr_d;
  logic [15:0] low_q, low_d;
  logic [2:0]  command_q, command_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  bank_q, bank_d;
  logic [15:0] data_out_q, data_out_d;
  logic [1:0]  data_mask_q, data_mask_d;
  logic        fifo_rd_q, fifo_rd_d;
  logic        go;

  assign command   = command_q;
  assign addr      = addr_q;
  assign bank      = bank_q;
  assign data_out  = data_out_q;
  assign data_mask = data_mask_q;
  assign fifo_rd   = fifo_rd_q;
  assign ready     = (state_q == S_IDLE) && (delay_q == 4'd0);
  assign go        = en && !fifo_empty;

  // Next-state and registered command/data outputs
  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    lauto_d     = lauto_q | auto_rfrsh;
    laddr_d     = laddr_q;
    low_d       = low_q;
    command_d   = CMD_NOP;
    addr_d      = addr_q;
    bank_d      = bank_q;
    data_out_d  = data_out_q;
    data_mask_d = 2'b11;
    fifo_rd_d   = 1'b0;
    if (delay_q != 4'd0) begin
      delay_d = delay_q - 4'd1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (lauto_q) begin
            state_d = S_PRECHARGE;
          end else if (go) begin
            laddr_d = write_address;
            state_d = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          command_d = CMD_ACT;
          bank_d    = laddr_q[21:20];
          addr_d    = laddr_q[19:8];
          delay_d   = D_RCD;
          state_d   = S_WRITE_TOP;
        end
        S_WRITE_TOP: begin
          command_d   = CMD_WR;
          addr_d      = {4'b0000, laddr_q[7:0]};
          data_out_d  = fifo_data[31:16];
          data_mask_d = 2'b00;
          fifo_rd_d   = 1'b1;
          low_d       = fifo_data[15:0];
          laddr_d     = laddr_q + 22'd2;
          state_d     = S_WRITE_BOTTOM;
        end
        S_WRITE_BOTTOM: begin
          data_out_d  = low_q;
          data_mask_d = 2'b00;
          if (go && !lauto_q && (laddr_q[7:0] != 8'd0)) begin
            state_d = S_WRITE_TOP;
          end else begin
            delay_d = D_WR;
            state_d = S_PRECHARGE;
          end
        end
        S_PRECHARGE: begin
          command_d = CMD_PRE;
          addr_d    = 12'h400;
          delay_d   = D_RP;
          if (lauto_q) begin
            state_d = S_REFRESH;
          end else if (go) begin
            state_d = S_ACTIVE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_REFRESH: begin
          command_d = CMD_AR;
          lauto_d   = auto_rfrsh;
          delay_d   = D_RFC;
          state_d   = go ? S_ACTIVE : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      delay_q     <= 4'd0;
      lauto_q     <= 1'b0;
      laddr_q     <= 22'd0;
      low_q       <= 16'd0;
      command_q   <= CMD_NOP;
      addr_q      <= 12'd0;
      bank_q      <= 2'd0;
      data_out_q  <= 16'd0;
      data_mask_q <= 2'b11;
      fifo_rd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      lauto_q     <= lauto_d;
      laddr_q     <= laddr_d;
      low_q       <= low_d;
      command_q   <= command_d;
      addr_q      <= addr_d;
      bank_q      <= bank_d;
      data_out_q  <= data_out_d;
      data_mask_q <= data_mask_d;
      fifo_rd_q   <= fifo_rd_d;
    end
  end

endmodule

// File: tb/tb_sdram_write.sv
// tb_sdram_write: scoreboard bench for sdram_write.
// Transaction-level timeline model feeds an expected-event queue.
module tb_sdram_write;

  localparam int T_RCD = 2;
  localparam int T_WR  = 2;
  localparam int T_RP  = 2;
  localparam int T_RFC = 8;

  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] ACT = 3'b011;
  localparam logic [2:0] WR  = 3'b100;
  localparam logic [2:0] PRE = 3'b010;
  localparam logic [2:0] AR  = 3'b001;

  logic        clk, rst;
  logic [2:0]  command;
  logic [11:0] addr;
  logic [1:0]  bank;
  logic [15:0] data_out;
  logic [1:0]  data_mask;
  logic        en;
  logic [21:0] write_address;
  logic        ready;
  logic        auto_rfrsh;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;

  sdram_write #(
    .T_RCD(T_RCD), .T_WR(T_WR), .T_RP(T_RP), .T_RFC(T_RFC)
  ) dut (
    .clk(clk), .rst(rst),
    .command(command), .addr(addr), .bank(bank),
    .data_out(data_out), .data_mask(data_mask),
    .en(en), .write_address(write_address), .ready(ready),
    .auto_rfrsh(auto_rfrsh),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  cmd;
    bit          chk_ba;
    logic [1:0]  ba;
    logic [11:0] ad;
    logic [11:0] am;
    logic [1:0]  dm;
    bit          chk_d;
    logic [15:0] d;
    logic        rd;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] fifo_q[$];
  int          wcyc[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  function automatic ev_t mk(input int c, input logic [2:0] cmd,
                             input bit chk_ba, input logic [1:0] ba,
                             input logic [11:0] ad, input logic [11:0] am,
                             input logic [1:0] dm, input bit chk_d,
                             input logic [15:0] d, input logic rd);
    ev_t e;
    e.cyc = c; e.cmd = cmd; e.chk_ba = chk_ba; e.ba = ba;
    e.ad = ad; e.am = am; e.dm = dm; e.chk_d = chk_d;
    e.d = d; e.rd = rd;
    return e;
  endfunction

  task automatic fifo_sync();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 32'h0 : fifo_q[0];
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // FWFT FIFO: head advances right after the pop strobe is seen
  always @(posedge clk) begin
    #1;
    if (fifo_rd === 1'b1) begin
      if (fifo_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL fifo_pop_empty cyc=%0d", cyc);
      end else begin
        void'(fifo_q.pop_front());
      end
      fifo_sync();
    end
  end

  // Monitor: every non-idle bus cycle is matched against the queue
  always @(posedge clk) begin
    ev_t e;
    bit  bad;
    cyc++;
    #1;
    if (command !== NOP || data_mask !== 2'b11 || fifo_rd !== 1'b0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d cmd=%b addr=%h dm=%b rd=%b",
                 cyc, command, addr, data_mask, fifo_rd);
      end else begin
        e = exp_q.pop_front();
        bad = (cyc != e.cyc) || (command !== e.cmd) ||
              (data_mask !== e.dm) || (fifo_rd !== e.rd) ||
              (ready !== 1'b0) ||
              ((addr & e.am) !== (e.ad & e.am)) ||
              (e.chk_ba && (bank !== e.ba)) ||
              (e.chk_d && (data_out !== e.d));
        if (bad) begin
          miscompares++;
          $display("FAIL bus_event got cyc=%0d cmd=%b ba=%h a=%h dm=%b d=%h rd=%b rdy=%b want cyc=%0d cmd=%b ba=%h a=%h dm=%b d=%h rd=%b rdy=0",
                   cyc, command, bank, addr, data_mask, data_out, fifo_rd,
                   ready, e.cyc, e.cmd, e.ba, e.ad, e.dm, e.d, e.rd);
        end
      end
    end
  end

  // Timeline model: ACT, WRITE/data pairs, PRE, AR from address rules
  task automatic model(input logic [21:0] a0, input logic [31:0] w[$],
                       input int r, input int t0);
    logic [21:0] a;
    int c, b, p, nx, n;
    a = a0;
    n = w.size();
    wcyc.delete();
    c = t0 + 1;
    exp_q.push_back(mk(c, ACT, 1, a[21:20], a[19:8], 12'hFFF,
                       2'b11, 0, 16'h0, 1'b0));
    c = c + T_RCD;
    for (int i = 0; i < n; i++) begin
      wcyc.push_back(c);
      exp_q.push_back(mk(c, WR, 1, a[21:20], {4'h0, a[7:0]}, 12'hFFF,
                         2'b00, 1, w[i][31:16], 1'b1));
      b = c + 1;
      exp_q.push_back(mk(b, NOP, 0, 2'b00, 12'h0, 12'h0,
                         2'b00, 1, w[i][15:0], 1'b0));
      a = a + 22'd2;
      if (i < n - 1 && i != r && a[7:0] != 8'h00) begin
        c = b + 1;
      end else begin
        p = b + T_WR + 1;
        exp_q.push_back(mk(p, PRE, 0, 2'b00, 12'h400, 12'h400,
                           2'b11, 0, 16'h0, 1'b0));
        nx = p + T_RP;
        if (i == r) begin
          exp_q.push_back(mk(nx, AR, 0, 2'b00, 12'h0, 12'h0,
                             2'b11, 0, 16'h0, 1'b0));
          nx = nx + T_RFC;
        end
        if (i < n - 1) begin
          exp_q.push_back(mk(nx, ACT, 1, a[21:20], a[19:8], 12'hFFF,
                             2'b11, 0, 16'h0, 1'b0));
          c = nx + T_RCD;
        end
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout left=%0d next_cyc=%0d",
               exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic wait_ready();
    int i;
    i = 0;
    while (ready !== 1'b1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout got=%b want=1", ready);
    end
  endtask

  task automatic run_burst(input logic [21:0] a0, input logic [31:0] w[$],
                           input int r);
    int t0;
    wait_ready();
    @(negedge clk);
    write_address = a0;
    foreach (w[i]) fifo_q.push_back(w[i]);
    fifo_sync();
    en = 1'b1;
    t0 = cyc + 1;
    model(a0, w, r, t0);
    if (r >= 0) begin
      while (cyc < wcyc[r] - 1) @(negedge clk);
      auto_rfrsh = 1'b1;
      @(negedge clk);
      auto_rfrsh = 1'b0;
    end
    wait_drain(300);
    en = 1'b0;
    repeat (T_RFC + 2) @(negedge clk);
    chk("ready_after_burst", {31'd0, ready}, 32'd1);
  endtask

  task automatic idle_refresh();
    int k;
    wait_ready();
    @(negedge clk);
    k = cyc;
    auto_rfrsh = 1'b1;
    exp_q.push_back(mk(k + 3, PRE, 0, 2'b00, 12'h400, 12'h400,
                       2'b11, 0, 16'h0, 1'b0));
    exp_q.push_back(mk(k + 3 + T_RP, AR, 0, 2'b00, 12'h0, 12'h0,
                       2'b11, 0, 16'h0, 1'b0));
    @(negedge clk);
    auto_rfrsh = 1'b0;
    wait_drain(50);
    repeat (T_RFC + 2) @(negedge clk);
    chk("ready_after_refresh", {31'd0, ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd"}, {29'd0, command}, {29'd0, NOP});
    chk({tag, "_addr"}, {20'd0, addr}, 32'd0);
    chk({tag, "_bank"}, {30'd0, bank}, 32'd0);
    chk({tag, "_dout"}, {16'd0, data_out}, 32'd0);
    chk({tag, "_dm"}, {30'd0, data_mask}, 32'd3);
    chk({tag, "_rd"}, {31'd0, fifo_rd}, 32'd0);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic reset_mid_burst(input logic [21:0] a0);
    logic [31:0] w[$];
    int t0;
    w.push_back($urandom);
    w.push_back($urandom);
    wait_ready();
    @(negedge clk);
    write_address = a0;
    foreach (w[i]) fifo_q.push_back(w[i]);
    fifo_sync();
    en = 1'b1;
    t0 = cyc + 1;
    model(a0, w, -1, t0);
    while (exp_q.size() > 0 && exp_q[$].cyc > wcyc[0])
      void'(exp_q.pop_back());
    while (cyc < wcyc[0]) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    chk("rst_mid_events_left", exp_q.size(), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    en = 1'b0;
    fifo_q.delete();
    fifo_sync();
    repeat (3) @(negedge clk);
    chk("rst_mid_idle_ready", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] w[$];
    logic [21:0] a;
    int n, r;
    rst = 1'b1;
    en = 1'b0;
    auto_rfrsh = 1'b0;
    write_address = 22'd0;
    fifo_sync();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    w = {32'hDEADBEEF};
    run_burst(22'h123410, w, -1);
    w = {32'h11112222, 32'h33334444, 32'h55556666};
    run_burst(22'h00A110, w, -1);
    w = {32'hA0A0B0B0, 32'hC0C0D0D0};
    run_burst(22'h0005FE, w, -1);
    w = {32'h01020304, 32'h05060708};
    run_burst(22'h0FFFFE, w, -1);
    w = {32'h0BADF00D, 32'hCAFEBABE};
    run_burst(22'h3FFFFE, w, -1);
    w = {32'h10001001, 32'h20002002, 32'h30003003, 32'h40004004};
    run_burst(22'h104020, w, 1);
    idle_refresh();
    w = {32'hFACE0001};
    run_burst(22'h2ABC40, w, -1);
    reset_mid_burst(22'h0C3380);

    for (int k = 0; k < 30; k++) begin
      a[21:20] = 2'($urandom_range(0, 3));
      a[19:8]  = 12'($urandom);
      if ($urandom_range(0, 2) == 0)
        a[7:0] = 8'hF8 + 8'(2 * $urandom_range(0, 3));
      else
        a[7:0] = {7'($urandom), 1'b0};
      n = $urandom_range(1, 6);
      r = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      w.delete();
      for (int j = 0; j < n; j++) w.push_back($urandom);
      run_burst(a, w, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
